// File: rtl/debounce_bank_pkg.sv
// ---------------------------------------------------------------------------
// debounce_bank_pkg
//   Small helpers shared by the debouncer files.
//   inactive_raw(): raw pin level that means "not pressed" for a given
//   polarity; used as the synchroniser reset value so that leaving reset
//   never looks like an edge.
// ---------------------------------------------------------------------------
package debounce_bank_pkg;

    function automatic logic inactive_raw(input logic active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//   One debouncer channel: synchroniser, symmetric filter counter, optional
//   long-press hold counter and registered edge pulses.
//
//   Ports:
//     clk         clock
//     resetn      synchronous active-low reset
//     in          raw asynchronous input
//     level       debounced active-high state
//     rise        one-cycle pulse when level goes 0->1
//     fall        one-cycle pulse when level goes 1->0
//     long_press  one-cycle pulse after level has been 1 for HOLD_COUNT cycles
// ---------------------------------------------------------------------------
module debounce_channel
    import debounce_bank_pkg::*;
#(
    parameter int MAX_COUNT   = 512,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 0,
    parameter int HOLD_COUNT  = 0
) (
    input  logic clk,
    input  logic resetn,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int             CW       = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_COUNT - 1);
    localparam logic           AL_BIT   = (ACTIVE_LOW != 0);
    localparam logic           INACTIVE = inactive_raw(AL_BIT);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Synchroniser chain and filter. Any cycle where s agrees with the stable
    // level clears the count, so only MAX_COUNT consecutive disagreeing cycles
    // flip the level; the new level and its edge pulse appear together.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], in};
        s       = sync_q[SYNC_STAGES-1] ^ AL_BIT;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q  <= {SYNC_STAGES{INACTIVE}};
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

    if (HOLD_COUNT > 0) begin : g_hold
        localparam int            HW       = $clog2(HOLD_COUNT + 1);
        localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_COUNT);

        logic [HW-1:0] hold_q, hold_d;
        logic          lp_q, lp_d;

        // The hold counter saturates so a long hold never wraps into a second
        // pulse. The pulse is suppressed if level drops in the same cycle the
        // count would complete, so long_press never coincides with fall.
        always_comb begin
            hold_d = '0;
            lp_d   = 1'b0;
            if (level_q) begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
                lp_d   = (hold_q == HOLD_MAX - 1'b1) && level_d;
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                hold_q <= '0;
                lp_q   <= 1'b0;
            end else begin
                hold_q <= hold_d;
                lp_q   <= lp_d;
            end
        end

        assign long_press = lp_q;
    end else begin : g_no_hold
        assign long_press = 1'b0;
    end

endmodule

// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//   NUM_CH independent debouncer channels sharing clock and reset.
//
//   Ports:
//     clk         clock
//     resetn      synchronous active-low reset
//     in          raw asynchronous inputs, one per channel
//     level       debounced active-high states
//     rise        one-cycle 0->1 pulses
//     fall        one-cycle 1->0 pulses
//     long_press  one-cycle long-press pulses (0 when HOLD_COUNT == 0)
// ---------------------------------------------------------------------------
module debounce_bank #(
    parameter int NUM_CH      = 4,
    parameter int MAX_COUNT   = 512,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 0,
    parameter int HOLD_COUNT  = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] in,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] long_press
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .MAX_COUNT   (MAX_COUNT),
            .SYNC_STAGES (SYNC_STAGES),
            .ACTIVE_LOW  (ACTIVE_LOW),
            .HOLD_COUNT  (HOLD_COUNT)
        ) u_channel (
            .clk        (clk),
            .resetn     (resetn),
            .in         (in[ch]),
            .level      (level[ch]),
            .rise       (rise[ch]),
            .fall       (fall[ch]),
            .long_press (long_press[ch])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_debounce_bank
//   Three debounce_bank instances with different configurations:
//     a: NUM_CH=4 MAX_COUNT=4 SYNC_STAGES=2 ACTIVE_LOW=0 HOLD_COUNT=10
//     b: NUM_CH=2 MAX_COUNT=4 SYNC_STAGES=2 ACTIVE_LOW=1 HOLD_COUNT=0
//     c: NUM_CH=2 MAX_COUNT=1 SYNC_STAGES=3 ACTIVE_LOW=0 HOLD_COUNT=3
//   A reference model keeps a history of synchronised samples and flips a
//   level only when the last MAX_COUNT samples all disagree with it; it
//   pushes the expected outputs per cycle and a monitor compares them.
// ---------------------------------------------------------------------------
module tb_debounce_bank;

    localparam int NI = 3;
    localparam int CFG_N    [NI] = '{4, 2, 2};
    localparam int CFG_MAX  [NI] = '{4, 4, 1};
    localparam int CFG_SYNC [NI] = '{2, 2, 3};
    localparam int CFG_AL   [NI] = '{0, 1, 0};
    localparam int CFG_HOLD [NI] = '{10, 0, 3};

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] in_a = 4'b0000;
    logic [1:0] in_b = 2'b11;
    logic [1:0] in_c = 2'b00;

    logic [3:0] lev_a, rise_a, fall_a, lp_a;
    logic [1:0] lev_b, rise_b, fall_b, lp_b;
    logic [1:0] lev_c, rise_c, fall_c, lp_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    debounce_bank #(.NUM_CH(4), .MAX_COUNT(4), .SYNC_STAGES(2), .ACTIVE_LOW(0), .HOLD_COUNT(10)) u_a (
        .clk(clk), .resetn(resetn), .in(in_a),
        .level(lev_a), .rise(rise_a), .fall(fall_a), .long_press(lp_a));

    debounce_bank #(.NUM_CH(2), .MAX_COUNT(4), .SYNC_STAGES(2), .ACTIVE_LOW(1), .HOLD_COUNT(0)) u_b (
        .clk(clk), .resetn(resetn), .in(in_b),
        .level(lev_b), .rise(rise_b), .fall(fall_b), .long_press(lp_b));

    debounce_bank #(.NUM_CH(2), .MAX_COUNT(1), .SYNC_STAGES(3), .ACTIVE_LOW(0), .HOLD_COUNT(3)) u_c (
        .clk(clk), .resetn(resetn), .in(in_c),
        .level(lev_c), .rise(rise_c), .fall(fall_c), .long_press(lp_c));

    // Outputs of one instance packed as {long_press, fall, rise, level}, 4 bits each.
    function automatic logic [15:0] dut_vec(input int i);
        case (i)
            0:       return {lp_a, fall_a, rise_a, lev_a};
            1:       return {2'b00, lp_b, 2'b00, fall_b, 2'b00, rise_b, 2'b00, lev_b};
            default: return {2'b00, lp_c, 2'b00, fall_c, 2'b00, rise_c, 2'b00, lev_c};
        endcase
    endfunction

    function automatic logic raw_of(input int i, input int c);
        case (i)
            0:       return in_a[c[1:0]];
            1:       return in_b[c[0]];
            default: return in_c[c[0]];
        endcase
    endfunction

    task automatic set_raw(input int i, input int c, input logic v);
        case (i)
            0:       in_a[c[1:0]] = v;
            1:       in_b[c[0]]   = v;
            default: in_c[c[0]]   = v;
        endcase
    endtask

    // ---------------- reference model ----------------
    bit m_raw   [NI][4][4];   // last raw samples, [0] newest
    bit m_sw    [NI][4][4];   // last synchronised samples, [0] newest
    bit m_level [NI][4];
    int m_run   [NI][4];      // consecutive cycles with level high

    always @(posedge clk) begin : model
        logic [47:0] e;
        bit lv, nl, all_dis, s, rs, fl, lp;
        e = '0;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < CFG_N[i]; c++) begin
                rs = 1'b0; fl = 1'b0; lp = 1'b0;
                if (!resetn) begin
                    for (int j = 0; j < 4; j++) begin
                        m_raw[i][c][j] = (CFG_AL[i] != 0);
                        m_sw[i][c][j]  = 1'b0;
                    end
                    m_level[i][c] = 1'b0;
                    m_run[i][c]   = 0;
                    nl = 1'b0;
                end else begin
                    lv = m_level[i][c];
                    all_dis = 1'b1;
                    for (int j = 0; j < CFG_MAX[i]; j++)
                        if (m_sw[i][c][j] == lv) all_dis = 1'b0;
                    nl = all_dis ? ~lv : lv;
                    rs = nl & ~lv;
                    fl = lv & ~nl;
                    if (nl) m_run[i][c] = (m_run[i][c] < CFG_HOLD[i] + 2) ? m_run[i][c] + 1 : m_run[i][c];
                    else    m_run[i][c] = 0;
                    lp = (CFG_HOLD[i] > 0) && nl && (m_run[i][c] == CFG_HOLD[i] + 1);
                    m_level[i][c] = nl;
                    for (int j = 3; j > 0; j--) m_raw[i][c][j] = m_raw[i][c][j-1];
                    m_raw[i][c][0] = raw_of(i, c);
                    s = m_raw[i][c][CFG_SYNC[i]-1] ^ (CFG_AL[i] != 0);
                    for (int j = 3; j > 0; j--) m_sw[i][c][j] = m_sw[i][c][j-1];
                    m_sw[i][c][0] = s;
                end
                e[i*16 + c]      = nl;
                e[i*16 + 4 + c]  = rs;
                e[i*16 + 8 + c]  = fl;
                e[i*16 + 12 + c] = lp;
            end
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [47:0] e;
        logic [15:0] got, want;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < NI; i++) begin
                got  = dut_vec(i);
                want = e[i*16 +: 16];
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL outputs_inst%0d t=%0t: got {lp,fall,rise,level}=%h expected %h",
                             i, $time, got, want);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts negedges until the chosen pulse (0 = rise, 1 = long_press) is seen.
    task automatic measure(input int i, input int c, input int which, input int want, input string name);
        int n;
        logic hit;
        logic [15:0] v;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 60) begin
            @(negedge clk);
            n++;
            v = dut_vec(i);
            hit = (which == 0) ? v[4 + c] : v[12 + c];
        end
        n_checks++;
        if (!hit || n != want) begin
            n_fail++;
            $display("FAIL %s: pulse after %0d cycles (seen=%0b), expected %0d", name, n, hit, want);
        end
    endtask

    task automatic count_lp(input int c, input int cycles, input int want, input string name);
        int n;
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (lp_a[c[1:0]]) n++;
        end
        n_checks++;
        if (n != want) begin
            n_fail++;
            $display("FAIL %s: %0d long_press pulses, expected %0d", name, n, want);
        end
    endtask

    // ---------------- stimulus ----------------
    int cd [NI][4];

    initial begin
        resetn = 1'b0;
        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(4);

        // clean press
        in_a[0] = 1'b1;
        measure(0, 0, 0, 6, "clean_press_a0");
        wait_cycles(5);

        // glitch rejection, then a 4-cycle pulse that must pass
        in_a[1] = 1'b1; wait_cycles(3); in_a[1] = 1'b0; wait_cycles(15);
        in_a[1] = 1'b1; wait_cycles(4); in_a[1] = 1'b0; wait_cycles(20);

        // bounce then settle high
        for (int k = 0; k < 10; k++) begin
            in_a[2] = ~in_a[2];
            wait_cycles(2);
        end
        in_a[2] = 1'b1;
        measure(0, 2, 0, 6, "bounce_settle_a2");
        wait_cycles(5);

        // long press, held well past HOLD_COUNT
        in_a[3] = 1'b1;
        measure(0, 3, 0, 6, "press_a3");
        measure(0, 3, 1, 10, "long_press_a3");
        count_lp(3, 25, 0, "long_press_once_a3");
        in_a[3] = 1'b0; wait_cycles(12);
        // release so that level falls 9 cycles after rise
        in_a[3] = 1'b1;
        measure(0, 3, 0, 6, "repress_a3");
        wait_cycles(3);
        in_a[3] = 1'b0;
        count_lp(3, 20, 0, "short_hold_a3");

        // active-low instance
        in_b[0] = 1'b0;
        measure(1, 0, 0, 6, "active_low_press_b0");
        in_b[0] = 1'b1; wait_cycles(10);

        // MAX_COUNT = 1 instance, SYNC_STAGES = 3
        in_c[0] = 1'b1;
        measure(2, 0, 0, 4, "max1_press_c0");
        measure(2, 0, 1, 3, "max1_long_press_c0");
        in_c[0] = 1'b0; wait_cycles(8);

        // reset with the filter counter at 3
        in_a[0] = 1'b0; wait_cycles(10);
        in_a[0] = 1'b1; wait_cycles(5);
        resetn = 1'b0; wait_cycles(1);
        resetn = 1'b1;
        measure(0, 0, 0, 6, "after_reset_a0");
        wait_cycles(5);

        // randomized: random hold lengths per channel, occasional reset
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) cd[i][c] = $urandom_range(1, 12);
        repeat (3000) begin
            for (int i = 0; i < NI; i++) begin
                for (int c = 0; c < CFG_N[i]; c++) begin
                    cd[i][c]--;
                    if (cd[i][c] <= 0) begin
                        set_raw(i, c, ~raw_of(i, c));
                        cd[i][c] = $urandom_range(1, 14);
                    end
                end
            end
            resetn = ($urandom_range(0, 599) != 0);
            wait_cycles(1);
        end
        resetn = 1'b1;
        wait_cycles(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
